// File: rtl/detect_scheduler.sv
// detect_scheduler
//   Round-robin time-shares one Mealy "11" detector among four serial
//   requesters. Each requester keeps its own 1-bit context (last bit seen)
//   and a saturating detection counter, so a pattern split across two
//   grants is still detected.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   req[3:0]          : per-requester request for the detector
//   din[3:0]          : per-requester serial bit (used only while granted)
//   clr[3:0]          : synchronous clear of requester i's context and counter
//   cnt_sel[1:0]      : selects the counter shown on cnt_out
//   gnt[3:0]          : registered one-hot grant (or zero)
//   busy              : |gnt
//   det               : combinational detect pulse for the granted requester
//   det_id[1:0]       : index of the granted requester
//   cnt_out[CNT_W-1:0]: counter selected by cnt_sel

// Per-requester context bit and saturating detection counter.
module detect_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             consume,
  input  logic             din,
  input  logic             clr,
  input  logic             inc,
  output logic             ctx,
  output logic [CNT_W-1:0] cnt
);
  logic             ctx_q, ctx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr wins over a same-cycle consume or increment
  always_comb begin
    ctx_d = ctx_q;
    cnt_d = cnt_q;
    if (clr) begin
      ctx_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (consume) ctx_d = din;
      if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctx_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ctx_q <= ctx_d;
      cnt_q <= cnt_d;
    end
  end

  assign ctx = ctx_q;
  assign cnt = cnt_q;
endmodule

module detect_scheduler #(
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       din,
  input  logic [3:0]       clr,
  input  logic [1:0]       cnt_sel,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             det,
  output logic [1:0]       det_id,
  output logic [CNT_W-1:0] cnt_out
);
  localparam int NUM_LANES = 4;
  localparam int BC_W      = 4;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BURST - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [NUM_LANES-1:0]  gnt_q, gnt_d;
  logic [1:0]            gid_q, gid_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;

  logic [NUM_LANES-1:0]             ctx_all;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt_all;
  logic                             consume;
  logic [1:0]                       win;
  logic [1:0]                       idx;

  // A bit is consumed only while the granted requester still asks.
  assign consume = (state_q == RUN) && req[gid_q];
  assign det     = consume && ctx_all[gid_q] && din[gid_q];

  // Round-robin pick: scanning ptr+4 down to ptr+1 lets the closest
  // requester after ptr overwrite the others (ptr itself is searched last).
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (req != '0) begin
          state_d  = RUN;
          gnt_d    = NUM_LANES'(1) << win;
          gid_d    = win;
          bitcnt_d = '0;
        end
      end
      RUN: begin
        // Burst ends on a dropped request or on the last allowed bit;
        // IDLE is always visited so gnt drops for at least one cycle.
        if (!req[gid_q] || (bitcnt_q == LAST_BIT)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gid_q;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gid_q    <= 2'd0;
      ptr_q    <= 2'd3;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    detect_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .consume (consume && (gid_q == 2'(i))),
      .din     (din[i]),
      .clr     (clr[i]),
      .inc     (det && (gid_q == 2'(i))),
      .ctx     (ctx_all[i]),
      .cnt     (cnt_all[i])
    );
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign det_id  = gid_q;
  assign cnt_out = cnt_all[cnt_sel];
endmodule

// File: doc/detect_scheduler.md
DETECT_SCHEDULER -- requirements
Module: detect_scheduler

Interface
- REQ-001: Parameter BURST, default 4, SHALL set the maximum bits consumed per grant (legal range 1..15).
- REQ-002: Parameter CNT_W, default 8, SHALL set the width of each per-requester detection counter.
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on posedge clk.
- REQ-004: reset  input  1  SHALL be an asynchronous, active-high reset.
- REQ-005: req  input  4  SHALL carry the per-requester request; bit i asks for use of the shared "11" detector.
- REQ-006: din  input  4  SHALL carry the per-requester serial data bit; din[i] is meaningful only while gnt[i]=1.
- REQ-007: clr  input  4  SHALL be a synchronous clear of requester i's context bit and counter.
- REQ-008: cnt_sel  input  2  SHALL select which counter drives cnt_out.
- REQ-009: gnt  output  4  SHALL be a registered one-hot grant, or all zeros.
- REQ-010: busy  output  1  SHALL equal |gnt.
- REQ-011: det  output  1  SHALL be the combinational Mealy detect pulse for the granted requester.
- REQ-012: det_id  output  2  SHALL be the index of the granted requester (registered gid).
- REQ-013: cnt_out  output  CNT_W  SHALL be combinationally cnt[cnt_sel].

Function
- REQ-014: Per requester i, the block SHALL hold a 1-bit context ctx[i] (0 = state A, "last bit 0"; 1 = state B, "last bit 1") and a counter cnt[i].
- REQ-015: The controller SHALL have two states: IDLE and RUN.
- REQ-016: In IDLE with req != 0, the block SHALL pick the winner round-robin, searching ptr+1, ptr+2, ptr+3, ptr (mod 4), then load gnt = onehot(winner), gid = winner, bitcnt = 0, and enter RUN on the next edge.
- REQ-017: In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
- REQ-018: In RUN, if req[gid]=1, the block SHALL consume din[gid]: ctx[gid] <= din[gid]; bitcnt <= bitcnt+1.
- REQ-019: det SHALL be asserted iff state == RUN, req[gid]=1, ctx[gid]=1, and din[gid]=1; when det=1, cnt[gid] SHALL increment, saturating at all-ones.
- REQ-020: In RUN, the burst SHALL end on the same edge that consumes the bit when bitcnt == BURST-1; the block SHALL then go to IDLE with gnt <= 0 and ptr <= gid.
- REQ-021: In RUN, if req[gid]=0, no bit SHALL be consumed, det SHALL be 0, and the burst SHALL end (IDLE, gnt <= 0, ptr <= gid).
- REQ-022: Every burst SHALL be followed by at least one IDLE cycle, so gnt is low for at least one cycle between grants.
- REQ-023: Latency SHALL be one cycle: req sampled in IDLE at edge t gives gnt high after edge t.
- REQ-024: ctx[i] SHALL persist across bursts, so a pattern split across two grants of requester i is detected.
- REQ-025: clr[i]=1 SHALL set ctx[i] <= 0 and cnt[i] <= 0 on the next edge; clr takes priority over a same-cycle consume or increment for i; det remains combinational and unaffected.
- REQ-026: clr SHALL NOT affect the grant, bitcnt, or FSM state.
- REQ-027: Changes on req[j] for j != gid during RUN SHALL have no effect until IDLE.

Reset
- REQ-028: While reset=1, the block SHALL hold state = IDLE, gnt = 0, gid = 0, bitcnt = 0, ptr = 3 (requester 0 has first priority), ctx = 0, and cnt[*] = 0; det and busy SHALL read 0.
- REQ-029: Reset asserted mid-burst SHALL immediately drop gnt and discard the burst; counters and contexts SHALL return to 0.

Verification
- REQ-030: Apply reset, then release with req=0 -> gnt=0, busy=0, det=0, cnt_out=0 for every cnt_sel.
- REQ-031: Set req=0001 and din[0] = 1,1,1,0 over RUN cycles -> gnt=0001 for exactly 4 cycles starting one cycle after req; det high on the 2nd and 3rd bits; cnt[0]=2; gnt=0 the following cycle.
- REQ-032: Context carry: req1 burst ends with bit 1, a req2 burst intervenes, then req1's next burst starts with bit 1 -> det=1 on that first bit, det_id=1.
- REQ-033: Hold req=1111 continuously -> grant order 0,1,2,3,0; each grant lasts 4 cycles, separated by 1 idle cycle.
- REQ-034: Requester 0 drops req after 2 bits while req=0011 -> gnt0 falls the next cycle, requester 1 is granted after one IDLE cycle, and ctx[0] keeps the last consumed bit.
- REQ-035: With CNT_W=2, drive 5 detections on requester 3 -> cnt[3]=3 (saturated); then clr[3] in the same cycle as a detect -> cnt[3]=0 and ctx[3]=0 next cycle.
